// File: rtl/atconv_host_pkg.sv
// Shared widths, default frame sizes and FSM state encoding for the
// atrous-convolution host controller.
package atconv_host_pkg;

  localparam int unsigned DATA_W        = 13;
  localparam int unsigned ADDR_W        = 12;
  localparam int unsigned IMG_WORDS_DEF = 4096;
  localparam int unsigned RES_WORDS_DEF = 1024;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    RUN,
    READ,
    CAPT,
    SEND,
    DONE
  } state_t;

endpackage

// File: rtl/atconv_host.sv
// Host sequencer: streams an image into the accelerator RAM, hands off via
// ready/busy, then reads layer-1 results back out as a valid/ready stream.
module atconv_host
  import atconv_host_pkg::*;
#(
  parameter int unsigned IMG_WORDS = IMG_WORDS_DEF,
  parameter int unsigned RES_WORDS = RES_WORDS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              img_we,
  output logic [ADDR_W-1:0] img_waddr,
  output logic [DATA_W-1:0] img_wdata,
  output logic              ready,
  input  logic              busy,
  output logic              crd,
  output logic [ADDR_W-1:0] caddr_rd,
  input  logic [DATA_W-1:0] cdata_rd,
  output logic              csel,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              done
);

  localparam logic [ADDR_W-1:0] IMG_LAST = ADDR_W'(IMG_WORDS - 1);
  localparam logic [ADDR_W-1:0] RES_LAST = ADDR_W'(RES_WORDS - 1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] cnt, cnt_next;

  // One counter serves both the load and the read-back phase; they never overlap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      out_data <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (state == CAPT) out_data <= cdata_rd;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    in_ready   = 1'b0;
    img_we     = 1'b0;
    img_waddr  = '0;
    img_wdata  = '0;
    ready      = 1'b0;
    crd        = 1'b0;
    caddr_rd   = '0;
    csel       = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    done       = 1'b0;

    unique case (state)
      IDLE: begin
        state_next = LOAD;
        cnt_next   = '0;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          img_we    = 1'b1;
          img_waddr = cnt;
          img_wdata = in_data;
          if (cnt == IMG_LAST) begin
            state_next = START;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      START: begin
        ready = 1'b1;
        if (busy) state_next = RUN;
      end
      RUN: begin
        if (!busy) begin
          state_next = READ;
          cnt_next   = '0;
        end
      end
      READ: begin
        crd        = 1'b1;
        csel       = 1'b1;
        caddr_rd   = cnt;
        state_next = CAPT;
      end
      CAPT: begin
        csel       = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        csel      = 1'b1;
        out_valid = 1'b1;
        out_last  = (cnt == RES_LAST);
        if (out_ready) begin
          if (cnt == RES_LAST) begin
            state_next = DONE;
            cnt_next   = '0;
          end else begin
            state_next = READ;
            cnt_next   = cnt + 1'b1;
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = LOAD;
        cnt_next   = '0;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_atconv_host.sv
// Self-checking bench for atconv_host: directed vector table around reset and
// load start, then full frames against a procedural model of the frame protocol.
module tb_atconv_host;
  import atconv_host_pkg::*;

  localparam int unsigned IW = IMG_WORDS_DEF;
  localparam int unsigned RW = RES_WORDS_DEF;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [12:0] in_data;
  logic        in_ready;
  logic        img_we;
  logic [11:0] img_waddr;
  logic [12:0] img_wdata;
  logic        ready;
  logic        busy;
  logic        crd;
  logic [11:0] caddr_rd;
  logic [12:0] cdata_rd;
  logic        csel;
  logic        out_valid;
  logic [12:0] out_data;
  logic        out_last;
  logic        out_ready;
  logic        done;

  int unsigned errors = 0;
  int unsigned checks = 0;

  atconv_host #(.IMG_WORDS(IW), .RES_WORDS(RW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .img_we(img_we), .img_waddr(img_waddr),
    .img_wdata(img_wdata), .ready(ready), .busy(busy), .crd(crd),
    .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Layer memory: data valid the cycle after crd, value = address + 5; junk otherwise.
  always @(posedge clk) begin
    if (crd) cdata_rd <= 13'(caddr_rd + 12'd5);
    else     cdata_rd <= 13'($urandom);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        iv;
    logic [12:0] d;
    logic        e_ir;
    logic        e_we;
    logic [11:0] e_wa;
    logic [12:0] e_wd;
  } vec_t;

  vec_t tbl [9];

  task automatic load_frame(input int unsigned mode);
    int unsigned n = 0;
    int unsigned budget = 0;
    bit seen [IW];
    while (n < IW && budget < 4 * IW) begin
      @(posedge clk); #1;
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (budget % 2 == 0);
        default: begin
          in_valid = 1'($urandom % 2);
          busy     = 1'($urandom % 2);
        end
      endcase
      in_data = (mode == 0) ? 13'(n) : 13'($urandom);
      @(negedge clk);
      budget++;
      chk("load_in_ready", in_ready, 1);
      chk("load_we", img_we, in_valid);
      chk("load_quiet", {ready, crd, csel, out_valid, done}, 0);
      if (in_valid) begin
        chk("load_waddr", img_waddr, n);
        chk("load_wdata", img_wdata, in_data);
        chk("load_dup", seen[img_waddr], 0);
        seen[img_waddr] = 1'b1;
        n++;
      end
    end
    chk("load_count", n, IW);
    // Cycle after the final word: ready up, further input ignored.
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 13'h0AAA;
    busy     = 1'b0;
    @(negedge clk);
    chk("start_ready", ready, 1);
    chk("start_in_ready", in_ready, 0);
    chk("start_no_write", img_we, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic start_run(input int unsigned lo, input int unsigned hi);
    @(negedge clk);
    chk("start_hold_ready", ready, 1);
    repeat (lo) begin
      @(posedge clk); #1; busy = 1'b0;
      @(negedge clk);
      chk("start_hold_ready", ready, 1);
      chk("start_no_crd", crd, 0);
    end
    @(posedge clk); #1; busy = 1'b1;
    @(negedge clk);
    chk("busy_first_ready", ready, 1);
    repeat (hi - 1) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("run_ready_low", ready, 0);
      chk("run_no_crd", crd, 0);
    end
    @(posedge clk); #1; busy = 1'b0;
    @(negedge clk);
    chk("run_ready_low", ready, 0);
    chk("run_no_crd", crd, 0);
  endtask

  task automatic readback(input int unsigned abort_at);
    for (int unsigned k = 0; k < RW; k++) begin
      int unsigned waited = 0;
      bit got = 0;
      bit seen_valid = 0;
      while (!got && waited < 64) begin
        @(posedge clk); #1;
        out_ready = (k == abort_at) ? 1'b0 : 1'($urandom % 2);
        @(negedge clk);
        waited++;
        chk("done_idle", done, 0);
        if (crd) begin
          chk("read_lat", waited, 1);
          chk("read_addr", caddr_rd, k);
          chk("read_csel", csel, 1);
        end
        if (out_valid) begin
          if (!seen_valid) chk("send_lat", waited, 3);
          seen_valid = 1;
          chk("out_data", out_data, k + 5);
          chk("out_last", out_last, (k == RW - 1));
          chk("send_csel", csel, 1);
          if (k == abort_at) begin
            @(posedge clk); #1;
            reset = 1'b1; in_valid = 1'b1; in_data = 13'h1234;
            @(negedge clk);
            chk("abort_still_send", out_valid, 1);
            @(posedge clk); #1;
            reset = 1'b0;
            @(negedge clk);
            chk("rst_ctrl", {in_ready, img_we, ready, crd, csel, out_valid, out_last, done}, 0);
            chk("rst_addr", {img_waddr, caddr_rd}, 0);
            chk("rst_wdata", img_wdata, 0);
            chk("rst_out_data", out_data, 0);
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            chk("abort_reload", in_ready, 1);
            return;
          end
          if (out_ready) got = 1;
        end
      end
      if (!got) begin
        chk("send_timeout", got, 1);
        return;
      end
    end
    @(posedge clk); #1; out_ready = 1'b0;
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("done_no_valid", out_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_single", done, 0);
    chk("next_frame_load", in_ready, 1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; busy = 1'b0; out_ready = 1'b0;
    cdata_rd = '0;
    //            rst   iv    d         ir    we    wa      wd
    tbl[0] = '{1'b1, 1'b1, 13'h0111, 1'b0, 1'b0, 12'd0, 13'h0000};
    tbl[1] = '{1'b0, 1'b1, 13'h0222, 1'b0, 1'b0, 12'd0, 13'h0000};
    tbl[2] = '{1'b0, 1'b0, 13'h0333, 1'b1, 1'b0, 12'd0, 13'h0000};
    tbl[3] = '{1'b0, 1'b1, 13'h00AB, 1'b1, 1'b1, 12'd0, 13'h00AB};
    tbl[4] = '{1'b0, 1'b1, 13'h1FFF, 1'b1, 1'b1, 12'd1, 13'h1FFF};
    tbl[5] = '{1'b0, 1'b0, 13'h0444, 1'b1, 1'b0, 12'd0, 13'h0000};
    tbl[6] = '{1'b1, 1'b0, 13'h0055, 1'b1, 1'b0, 12'd0, 13'h0000};
    tbl[7] = '{1'b0, 1'b1, 13'h0555, 1'b0, 1'b0, 12'd0, 13'h0000};
    tbl[8] = '{1'b0, 1'b1, 13'h0777, 1'b1, 1'b1, 12'd0, 13'h0777};
    repeat (2) @(posedge clk);
    for (int unsigned i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      reset = tbl[i].rst; in_valid = tbl[i].iv; in_data = tbl[i].d;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].e_ir);
      chk($sformatf("vec%0d_we", i), img_we, tbl[i].e_we);
      chk($sformatf("vec%0d_waddr", i), img_waddr, tbl[i].e_wa);
      chk($sformatf("vec%0d_wdata", i), img_wdata, tbl[i].e_wd);
      chk($sformatf("vec%0d_quiet", i),
          {ready, crd, csel, out_valid, out_last, done, caddr_rd, out_data}, 0);
    end
    @(posedge clk); #1; reset = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 0);

    load_frame(0);
    start_run(19, 50);
    readback(RW);

    load_frame(1);
    start_run(3, 5);
    readback(300);

    load_frame(2);
    start_run(0, 1);
    readback(RW);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
